// File: rtl/tdm_demux_1x4_pkg.sv
// Shared TDM definitions: FSM state encoding, default geometry and clog2 helper.
// Also intended for use by the tdm_mux transmitter.
package tdm_demux_1x4_pkg;

    localparam int TDM_WIDTH = 8;
    localparam int TDM_LANES = 4;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tdm_slot_decode.sv
// Slot counter value plus write enable to one-hot lane enable.
// Feeds both the shadow-buffer writes and the lane_strobe register.
module tdm_slot_decode #(
    parameter int LANES = 4,
    parameter int CW    = 2
) (
    input  logic [CW-1:0]    slot_i,
    input  logic             we_i,
    output logic [LANES-1:0] onehot_o
);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign onehot_o[gi] = we_i && (slot_i == CW'(gi));
    end

endmodule

// File: rtl/tdm_demux_1x4.sv
// Receive-side TDM demultiplexer: serial samples framed by a slot-0 marker into LANES lanes.
// Optional odd-parity checking is enabled with TDM_DEMUX_PARITY_EN.
module tdm_demux_1x4
    import tdm_demux_1x4_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int LANES = TDM_LANES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    input  logic                   frame_start,
    output logic [LANES*WIDTH-1:0] dout,
    output logic                   dout_valid,
    output logic [LANES-1:0]       lane_strobe,
    output logic                   frame_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    input  logic                   din_par,
    output logic                   par_err
`endif
);

    localparam int            CW   = clog2(LANES);
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    state_e                 state_q;
    logic [CW-1:0]          slot_cnt_q;
    logic [WIDTH-1:0]       shadow_q [LANES-1];
    logic [LANES*WIDTH-1:0] dout_q;
    logic                   dout_valid_q;
    logic [LANES-1:0]       lane_strobe_q;
    logic                   frame_err_q;

    logic                   wr_en;
    logic [CW-1:0]          wr_slot;
    logic                   restart;
    logic                   complete;
    logic [LANES-1:0]       wr_onehot;
    logic                   deliver;

    // Slot selection: a start (from IDLE) or a restart always targets slot 0.
    always_comb begin
        wr_en    = 1'b0;
        wr_slot  = '0;
        restart  = 1'b0;
        complete = 1'b0;
        if (din_valid) begin
            case (state_q)
                S_IDLE: wr_en = frame_start;
                S_COLLECT: begin
                    wr_en = 1'b1;
                    if (frame_start) begin
                        restart = 1'b1;
                    end else begin
                        wr_slot  = slot_cnt_q;
                        complete = (slot_cnt_q == LAST);
                    end
                end
                default: wr_en = 1'b0;
            endcase
        end
    end

    tdm_slot_decode #(
        .LANES (LANES),
        .CW    (CW)
    ) u_slot_decode (
        .slot_i   (wr_slot),
        .we_i     (wr_en),
        .onehot_o (wr_onehot)
    );

`ifdef TDM_DEMUX_PARITY_EN
    logic par_bad;
    logic bad_q;
    logic par_err_q;

    assign par_bad = wr_en && !(^{din, din_par});
    assign deliver = !(bad_q || par_bad);
    assign par_err = par_err_q;

    // A bad mark lives for one frame attempt; any slot-0 write starts it afresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_bad;
            if (wr_en) begin
                bad_q <= (wr_slot == '0) ? par_bad : (bad_q || par_bad);
            end
        end
    end
`else
    assign deliver = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            slot_cnt_q    <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            lane_strobe_q <= '0;
            frame_err_q   <= 1'b0;
            for (int i = 0; i < LANES - 1; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            lane_strobe_q <= wr_onehot;
            frame_err_q   <= restart;
            dout_valid_q  <= 1'b0;
            for (int i = 0; i < LANES - 1; i++) begin
                if (wr_onehot[i]) begin
                    shadow_q[i] <= din;
                end
            end
            if (wr_en) begin
                if (complete) begin
                    state_q    <= S_IDLE;
                    slot_cnt_q <= '0;
                    if (deliver) begin
                        // The last slot bypasses the shadow buffer straight into dout.
                        for (int i = 0; i < LANES - 1; i++) begin
                            dout_q[i*WIDTH +: WIDTH] <= shadow_q[i];
                        end
                        dout_q[(LANES-1)*WIDTH +: WIDTH] <= din;
                        dout_valid_q <= 1'b1;
                    end
                end else begin
                    state_q    <= S_COLLECT;
                    slot_cnt_q <= wr_slot + 1'b1;
                end
            end
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign lane_strobe = lane_strobe_q;
    assign frame_err   = frame_err_q;

endmodule
